demux_nch: RTL and testbench
============================

DEMUX_NCH -- requirements
Module: demux_nch

Interface
- REQ-001 SHALL have parameter DATA_SIZE, default 6, width of one data word including the channel-id field.
- REQ-002 SHALL have parameter N_CH, default 4, number of output channels, legal range 2..8.
- REQ-003 SHALL have parameter ID_W, default 2, channel-id field width, held in data_in[DATA_SIZE-1 -: ID_W]; SHALL be at least clog2(N_CH).
- REQ-004 SHALL use one clock and a synchronous, active-low reset: clk (input, 1 bit), rising-edge clock; reset_L (input, 1 bit), synchronous active-low reset.
- REQ-005 SHALL have fifo_empty, input, 1 bit: upstream show-ahead FIFO is empty; data_in is valid when low.
- REQ-006 SHALL have data_in, input, DATA_SIZE bits: head-of-line word from the upstream FIFO.
- REQ-007 SHALL have almost_full, input, N_CH bits: per-channel backpressure from the downstream FIFOs.
- REQ-008 SHALL have pop, output, 1 bit: dequeue strobe to the upstream FIFO.
- REQ-009 SHALL have push, output, N_CH bits: one-hot per-channel write strobe.
- REQ-010 SHALL have data_out, output, N_CH*DATA_SIZE bits: channel k occupies bits [k*DATA_SIZE +: DATA_SIZE].
- REQ-011 SHALL have id_err, output, 1 bit: one-cycle pulse when a word with an invalid channel id is dropped.
- REQ-012 SHALL have state, output, 2 bits: current FSM state.

Function
- REQ-013 SHALL compute dest = data_in[DATA_SIZE-1 -: ID_W]; dest >= N_CH is invalid.
- REQ-014 SHALL drive pop combinationally: pop = reset_L & ~fifo_empty & (invalid dest | ~almost_full[dest]).
- REQ-015 SHALL, on the edge where pop=1 with a valid dest, assert push[dest] for exactly one cycle starting the next cycle, with data_out slice dest = data_in captured at that edge; latency is 1 cycle.
- REQ-016 SHALL hold non-pushed data_out slices at their last value; push SHALL be zero on all channels not written.
- REQ-017 SHALL, when pop=1 with an invalid dest, assert no push and pulse id_err high the next cycle (drop).
- REQ-018 SHALL have FSM states IDLE=0, FWD=1, HOLD=2; next state: fifo_empty -> IDLE; else valid dest with almost_full[dest] high -> HOLD; else FWD.
- REQ-019 SHALL sustain one word per cycle in FWD with no bubbles when consecutive words target different channels.
- REQ-020 SHALL use head-of-line blocking: a word waiting in HOLD is never bypassed, even if other channels are free.
- REQ-021 SHALL leave HOLD for FWD on the cycle after almost_full[dest] falls, popping that same cycle.
- REQ-022 SHALL treat almost_full transitions as combinational on the current cycle only; no pipelined credit.

Reset
- REQ-023 SHALL, while reset_L=0 at a clk edge, clear push, data_out, id_err and counters to zero and set state to IDLE.
- REQ-024 SHALL force pop=0 during reset; reset mid-transfer SHALL discard the registered word and no push SHALL follow.

Configuration
- REQ-025 SHALL, when DEMUX_NCH_STATS_EN is defined, add output push_cnt (N_CH*16 bits, per-channel saturating push count) and output hold_cnt (16 bits, saturating count of cycles in HOLD), both cleared by reset.
- REQ-026 SHALL, without DEMUX_NCH_STATS_EN, have no counter logic and no push_cnt/hold_cnt ports.

Structure
- REQ-027 SHALL place the state encodings (IDLE/FWD/HOLD) and a clog2 function in shared package demux_pkg.
- REQ-028 SHALL implement each 16-bit saturating counter in sub-module demux_sat_cnt (inputs clk, reset_L, inc; output count), instantiated only under DEMUX_NCH_STATS_EN.

Verification
- REQ-029 SHALL cover: N_CH=4, words 0x05,0x1A,0x2F,0x33 back-to-back, no almost_full -> pop high 4 cycles; push 0001,0010,0100,1000 on the following cycles with matching data.
- REQ-030 SHALL cover: almost_full=0100, head 0x2F -> state HOLD, pop=0 for the duration; release -> pop next cycle, push=0100 one cycle later; hold_cnt equals the blocked cycles.
- REQ-031 SHALL cover: N_CH=3, ID_W=2, head 0x3C (id 3) -> pop=1, push=000, id_err pulse one cycle later.
- REQ-032 SHALL cover: reset_L low for one cycle immediately after a pop -> next cycle push=0, data_out=0, state IDLE.
- REQ-033 SHALL cover: fifo_empty=1 with almost_full=0 -> pop=0, state IDLE, no push.
- REQ-034 SHALL cover: with DEMUX_NCH_STATS_EN, 65540 pushes to channel 1 -> push_cnt[1]=0xFFFF (saturated).

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encodings, counter width and clog2 helper for demux_nch
package demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_HOLD = 2'd2
    } demux_state_e;

    localparam int CNT_W = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_sat_cnt.sv
// rtl/demux_sat_cnt.sv - 16-bit saturating event counter
module demux_sat_cnt
    import demux_pkg::*;
(
    input  logic             clk,
    input  logic             reset_L,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/demux_nch.sv
// rtl/demux_nch.sv - N-channel demux from a show-ahead FIFO; DEMUX_NCH_STATS_EN adds push/hold counters
module demux_nch
    import demux_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int N_CH      = 4,
    parameter int ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      fifo_empty,
    input  logic [DATA_SIZE-1:0]      data_in,
    input  logic [N_CH-1:0]           almost_full,
    output logic                      pop,
    output logic [N_CH-1:0]           push,
    output logic [N_CH*DATA_SIZE-1:0] data_out,
    output logic                      id_err,
    output logic [1:0]                state
`ifdef DEMUX_NCH_STATS_EN
    ,
    output logic [N_CH*CNT_W-1:0]     push_cnt,
    output logic [CNT_W-1:0]          hold_cnt
`endif
);

    demux_state_e              state_q;
    demux_state_e              state_d;
    logic [N_CH-1:0]           push_q;
    logic [N_CH-1:0]           push_d;
    logic [N_CH*DATA_SIZE-1:0] data_q;
    logic                      id_err_q;

    logic [ID_W-1:0] dest;
    logic            dest_ok;
    logic            dest_af;

    assign dest    = data_in[DATA_SIZE-1 -: ID_W];
    assign dest_ok = ({1'b0, dest} < (ID_W+1)'(N_CH));

    // Out-of-range ids never match a channel, so they see no backpressure and get dropped.
    always_comb begin
        dest_af = 1'b0;
        push_d  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (dest == ID_W'(k)) begin
                dest_af   = almost_full[k];
                push_d[k] = pop;
            end
        end
    end

    assign pop = reset_L & ~fifo_empty & (~dest_ok | ~dest_af);

    always_comb begin
        state_d = ST_FWD;
        if (fifo_empty) begin
            state_d = ST_IDLE;
        end else if (dest_ok && dest_af) begin
            state_d = ST_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q  <= ST_IDLE;
            push_q   <= '0;
            data_q   <= '0;
            id_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            push_q   <= push_d;
            id_err_q <= pop & ~dest_ok;
            for (int k = 0; k < N_CH; k++) begin
                if (push_d[k]) begin
                    data_q[k*DATA_SIZE +: DATA_SIZE] <= data_in;
                end
            end
        end
    end

    assign push     = push_q;
    assign data_out = data_q;
    assign id_err   = id_err_q;
    assign state    = state_q;

`ifdef DEMUX_NCH_STATS_EN
    for (genvar g = 0; g < N_CH; g++) begin : g_push_cnt
        demux_sat_cnt u_push_cnt (
            .clk     (clk),
            .reset_L (reset_L),
            .inc     (push_q[g]),
            .count   (push_cnt[g*CNT_W +: CNT_W])
        );
    end

    demux_sat_cnt u_hold_cnt (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (state_q == ST_HOLD),
        .count   (hold_cnt)
    );
`endif

endmodule

// File: tb/tb_demux_nch.sv
// tb/tb_demux_nch.sv - self-checking bench for demux_nch (4- and 3-channel instances, model + directed vectors)
module tb_demux_nch;

    logic       clk;
    logic       reset_L;
    logic       fifo_empty;
    logic [5:0] data_in;
    logic [7:0] af;

    logic        pop4, err4, pop3, err3;
    logic [3:0]  push4;
    logic [2:0]  push3;
    logic [23:0] dout4;
    logic [17:0] dout3;
    logic [1:0]  st4, st3;
`ifdef DEMUX_NCH_STATS_EN
    logic [63:0] pcnt4;
    logic [15:0] hcnt4;
    logic [47:0] pcnt3;
    logic [15:0] hcnt3;
`endif

    int checks   = 0;
    int failures = 0;

    demux_nch #(.DATA_SIZE(6), .N_CH(4), .ID_W(2)) u_dut4 (
        .clk         (clk),
        .reset_L     (reset_L),
        .fifo_empty  (fifo_empty),
        .data_in     (data_in),
        .almost_full (af[3:0]),
        .pop         (pop4),
        .push        (push4),
        .data_out    (dout4),
        .id_err      (err4),
        .state       (st4)
`ifdef DEMUX_NCH_STATS_EN
        ,
        .push_cnt    (pcnt4),
        .hold_cnt    (hcnt4)
`endif
    );

    demux_nch #(.DATA_SIZE(6), .N_CH(3), .ID_W(2)) u_dut3 (
        .clk         (clk),
        .reset_L     (reset_L),
        .fifo_empty  (fifo_empty),
        .data_in     (data_in),
        .almost_full (af[2:0]),
        .pop         (pop3),
        .push        (push3),
        .data_out    (dout3),
        .id_err      (err3),
        .state       (st3)
`ifdef DEMUX_NCH_STATS_EN
        ,
        .push_cnt    (pcnt3),
        .hold_cnt    (hcnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state, index 0 = 4-channel instance, index 1 = 3-channel instance.
    int         nch [2] = '{4, 3};
    int         m_push [2];
    logic [5:0] m_data [2][8];
    bit         m_err [2];
    int         m_state [2];

    function automatic int dest_of(input logic [5:0] w);
        return int'(w[5:4]);
    endfunction

    function automatic bit exp_pop(input int n);
        int d;
        d = dest_of(data_in);
        return reset_L && !fifo_empty && (d >= n || !af[d]);
    endfunction

    function automatic logic [63:0] exp_dout(input int i);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nch[i]; k++) begin
            v[k*6 +: 6] = m_data[i][k];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_L) begin
                m_push[i]  <= 0;
                m_err[i]   <= 1'b0;
                m_state[i] <= 0;
                for (int k = 0; k < 8; k++) m_data[i][k] <= '0;
            end else begin
                m_push[i] <= (exp_pop(nch[i]) && dest_of(data_in) < nch[i]) ? (1 << dest_of(data_in)) : 0;
                if (exp_pop(nch[i]) && dest_of(data_in) < nch[i]) m_data[i][dest_of(data_in)] <= data_in;
                m_err[i]   <= exp_pop(nch[i]) && dest_of(data_in) >= nch[i];
                m_state[i] <= fifo_empty ? 0 :
                              (dest_of(data_in) < nch[i] && af[dest_of(data_in)]) ? 2 : 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("pop4",   64'(pop4),   64'(exp_pop(4)));
            chk("push4",  64'(push4),  64'(m_push[0]));
            chk("dout4",  64'(dout4),  exp_dout(0));
            chk("err4",   64'(err4),   64'(m_err[0]));
            chk("state4", 64'(st4),    64'(m_state[0]));
            chk("pop3",   64'(pop3),   64'(exp_pop(3)));
            chk("push3",  64'(push3),  64'(m_push[1]));
            chk("dout3",  64'(dout3),  exp_dout(1));
            chk("err3",   64'(err3),   64'(m_err[1]));
            chk("state3", 64'(st3),    64'(m_state[1]));
        end
    end

    task automatic step(input bit rst, input bit e, input logic [5:0] d, input logic [3:0] a);
        @(posedge clk);
        #1;
        reset_L    = rst;
        fifo_empty = e;
        data_in    = d;
        af         = {4'b0, a};
        @(negedge clk);
    endtask

    initial begin
        reset_L    = 1'b0;
        fifo_empty = 1'b1;
        data_in    = '0;
        af         = '0;
        step(1'b0, 1'b1, 6'h00, 4'h0);
        step(1'b0, 1'b1, 6'h00, 4'h0);
        chk("rst_state", 64'(st4), 64'd0);
        chk("rst_push",  64'(push4), 64'd0);
        chk("rst_dout",  64'(dout4), 64'd0);
        chk("rst_pop",   64'(pop4), 64'd0);

        // Back-to-back words to channels 0..3, no backpressure.
        step(1'b1, 1'b0, 6'h05, 4'h0);
        chk("b2b_pop0", 64'(pop4), 64'd1);
        step(1'b1, 1'b0, 6'h1A, 4'h0);
        chk("b2b_push0", 64'(push4), 64'h1);
        chk("b2b_data0", 64'(dout4[5:0]), 64'h05);
        step(1'b1, 1'b0, 6'h2F, 4'h0);
        chk("b2b_push1", 64'(push4), 64'h2);
        chk("b2b_data1", 64'(dout4[11:6]), 64'h1A);
        step(1'b1, 1'b0, 6'h33, 4'h0);
        chk("b2b_push2", 64'(push4), 64'h4);
        chk("b2b_data2", 64'(dout4[17:12]), 64'h2F);
        chk("b2b_pop3", 64'(pop4), 64'd1);
        step(1'b1, 1'b1, 6'h00, 4'h0);
        chk("b2b_push3", 64'(push4), 64'h8);
        chk("b2b_data3", 64'(dout4[23:18]), 64'h33);
        chk("b2b_hold0", 64'(dout4[5:0]), 64'h05);
        chk("n3_err_33", 64'(err3), 64'd1);
        chk("n3_push_33", 64'(push3), 64'd0);

        // Empty FIFO: idle, no pop, no push.
        step(1'b1, 1'b1, 6'h00, 4'h0);
        chk("empty_pop", 64'(pop4), 64'd0);
        chk("empty_state", 64'(st4), 64'd0);
        chk("empty_push", 64'(push4), 64'd0);

        // Head-of-line hold on channel 2 for three blocked cycles, then release.
        step(1'b1, 1'b1, 6'h00, 4'h0);
`ifdef DEMUX_NCH_STATS_EN
        reset_L = 1'b0;
        step(1'b0, 1'b1, 6'h00, 4'h0);
`endif
        step(1'b1, 1'b0, 6'h2F, 4'b0100);
        chk("hold_pop_a", 64'(pop4), 64'd0);
        step(1'b1, 1'b0, 6'h2F, 4'b0100);
        chk("hold_state", 64'(st4), 64'd2);
        chk("hold_pop_b", 64'(pop4), 64'd0);
        step(1'b1, 1'b0, 6'h2F, 4'b0101);
        chk("hold_pop_c", 64'(pop4), 64'd0);
        step(1'b1, 1'b0, 6'h2F, 4'b0001);
        chk("release_pop", 64'(pop4), 64'd1);
        chk("release_nopush", 64'(push4), 64'd0);
        step(1'b1, 1'b1, 6'h00, 4'h0);
        chk("release_push", 64'(push4), 64'h4);
        chk("release_data", 64'(dout4[17:12]), 64'h2F);
        chk("release_state", 64'(st4), 64'd1);
`ifdef DEMUX_NCH_STATS_EN
        chk("hold_cnt", 64'(hcnt4), 64'd3);
`endif

        // Invalid id on the 3-channel instance is dropped with an id_err pulse.
        step(1'b1, 1'b0, 6'h3C, 4'h0);
        chk("inv_pop", 64'(pop3), 64'd1);
        step(1'b1, 1'b1, 6'h00, 4'h0);
        chk("inv_err", 64'(err3), 64'd1);
        chk("inv_push", 64'(push3), 64'd0);
        chk("n4_push_3c", 64'(push4), 64'h8);
        step(1'b1, 1'b1, 6'h00, 4'h0);
        chk("inv_err_end", 64'(err3), 64'd0);

        // Reset right after a pop discards the word.
        step(1'b1, 1'b0, 6'h05, 4'h0);
        step(1'b0, 1'b1, 6'h00, 4'h0);
        chk("rst_mid_pop", 64'(pop4), 64'd0);
        step(1'b1, 1'b1, 6'h00, 4'h0);
        chk("rst_mid_push", 64'(push4), 64'd0);
        chk("rst_mid_dout", 64'(dout4), 64'd0);
        chk("rst_mid_state", 64'(st4), 64'd0);

`ifdef DEMUX_NCH_STATS_EN
        step(1'b1, 1'b0, 6'h1A, 4'h0);
        repeat (65540) @(posedge clk);
        step(1'b1, 1'b1, 6'h00, 4'h0);
        step(1'b1, 1'b1, 6'h00, 4'h0);
        chk("push_cnt_sat", 64'(pcnt4[31:16]), 64'hFFFF);
        chk("push_cnt_ch0", 64'(pcnt4[15:0]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
